// File: rtl/flash_pkg.sv
// flash_pkg: shared mode encoding and counter width helper for the flash controller
package flash_pkg;
    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    function automatic int cw(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/flash_debounce.sv
// flash_debounce: two-flop synchronizer, stability counter and one-cycle rising press pulse
module flash_debounce
    import flash_pkg::*;
#(
    parameter int DEB_CYCLES = 625000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic stable,
    output logic press
);
    localparam int W = cw(DEB_CYCLES);
    localparam logic [W-1:0] CNT_MAX = W'(DEB_CYCLES - 1);

    logic s1_q, s2_q, stable_q, stable_d, prev_q, diff;
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        diff = s2_q != stable_q;
        cnt_d = (diff && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : '0;
        stable_d = (diff && cnt_q == CNT_MAX) ? s2_q : stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            stable_q <= 1'b0;
            prev_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q <= sw;
            s2_q <= s1_q;
            stable_q <= stable_d;
            prev_q <= stable_q;
            cnt_q <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign press = stable_q & ~prev_q;
endmodule

// File: rtl/flash_ctrl.sv
// flash_ctrl: press-driven OFF/ON/SLOW/FAST mode sequencer with prescaled LED blink
module flash_ctrl
    import flash_pkg::*;
#(
    parameter int DEB_CYCLES  = 625000,
    parameter int TICK_CYCLES = 62500,
    parameter int SLOW_TICKS  = 40,
    parameter int FAST_TICKS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw,
    output logic       ld,
    output logic [1:0] mode
);
    localparam int PW = cw(TICK_CYCLES);
    localparam int TW = cw(SLOW_TICKS > FAST_TICKS ? SLOW_TICKS : FAST_TICKS);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] SLOW_MAX = TW'(SLOW_TICKS - 1);
    localparam logic [TW-1:0] FAST_MAX = TW'(FAST_TICKS - 1);

    mode_e mode_q, mode_d;
    logic ld_q, ld_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic stable, press, step, blink, tick, flip;

    flash_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .stable(stable),
        .press(press)
    );

    // a press always wins over a same-cycle tick: counters restart from mode entry
    always_comb begin
        step = press & stable;
        blink = mode_q inside {MODE_SLOW, MODE_FAST};
        tick = blink && pre_q == PRE_MAX;
        flip = tick && tcnt_q == (mode_q == MODE_SLOW ? SLOW_MAX : FAST_MAX);
        mode_d = step ? mode_e'(mode_q + 2'd1) : mode_q;
        pre_d = (step || !blink || tick) ? '0 : pre_q + 1'b1;
        tcnt_d = (step || flip) ? '0 : tcnt_q + TW'(tick);
        ld_d = step ? (mode_d != MODE_OFF) : ld_q ^ flip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            ld_q <= 1'b0;
            pre_q <= '0;
            tcnt_q <= '0;
        end else begin
            mode_q <= mode_d;
            ld_q <= ld_d;
            pre_q <= pre_d;
            tcnt_q <= tcnt_d;
        end
    end

    assign ld = ld_q;
    assign mode = mode_q;
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: directed vector table plus randomized switch traffic against a behavioural model
module tb_flash_ctrl;
    localparam int DEB = 4, TICK = 5, SLOW = 4, FAST = 1;

    logic clk = 1'b0, rst = 1'b1, sw = 1'b0;
    logic ld;
    logic [1:0] mode;
    int tests = 0, fails = 0;
    bit chk = 0;

    flash_ctrl #(.DEB_CYCLES(DEB), .TICK_CYCLES(TICK), .SLOW_TICKS(SLOW), .FAST_TICKS(FAST)) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .ld(ld),
        .mode(mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r;
        bit s;
        int n;
        int m;
        bit l;
    } vec_t;
    vec_t tv[$];

    task automatic add(input bit r, input bit s, input int n, input int m, input bit l);
        vec_t v;
        v.r = r; v.s = s; v.n = n; v.m = m; v.l = l;
        tv.push_back(v);
    endtask

    // model: stable flips after DEB consecutive mismatching s2 samples; ld follows time since mode entry
    initial begin
        bit s1, s2, st, stp, p, r, s, el;
        int run, md, since, half;
        s1 = 0; s2 = 0; st = 0; stp = 0; run = 0; md = 0; since = 0;
        forever begin
            @(posedge clk);
            r = rst; s = sw;
            #1;
            if (r) begin
                s1 = 0; s2 = 0; st = 0; stp = 0; run = 0; md = 0; since = 0;
            end else begin
                p = st & ~stp;
                stp = st;
                if (s2 != st) begin
                    run++;
                    if (run == DEB) begin st = s2; run = 0; end
                end else run = 0;
                s2 = s1;
                s1 = s;
                if (p) begin md = (md + 1) % 4; since = 0; end
                else since++;
            end
            half = (md == 2 ? SLOW : FAST) * TICK;
            el = md == 0 ? 1'b0 : md == 1 ? 1'b1 : ((since / half) % 2 == 0);
            if (chk) begin
                tests++;
                if (mode !== 2'(md) || ld !== el) begin
                    fails++;
                    if (fails < 30)
                        $display("FAIL model t=%0t mode=%0d exp=%0d ld=%0d exp=%0d", $time, mode, md, ld, el);
                end
            end
        end
    end

    initial begin
        add(1, 0, 3, 0, 0);  add(0, 0, 50, 0, 0);
        add(0, 1, 6, 0, 0);  add(0, 1, 1, 1, 1);  add(0, 1, 13, 1, 1);  add(0, 0, 20, 1, 1);
        add(1, 0, 2, 0, 0);  add(0, 1, 3, 0, 0);  add(0, 0, 50, 0, 0);
        add(0, 1, 2, 0, 0);  add(0, 0, 2, 0, 0);  add(0, 1, 2, 0, 0);  add(0, 0, 2, 0, 0);
        add(0, 1, 2, 0, 0);  add(0, 1, 20, 1, 1);
        add(0, 0, 10, 1, 1); add(0, 1, 7, 2, 1);
        add(0, 1, 19, 2, 1); add(0, 1, 1, 2, 0);  add(0, 1, 19, 2, 0);  add(0, 1, 1, 2, 1);
        add(0, 0, 10, 2, 1); add(0, 1, 7, 3, 1);
        add(0, 1, 4, 3, 1);  add(0, 1, 1, 3, 0);  add(0, 1, 5, 3, 1);
        add(0, 0, 10, 3, 1); add(0, 1, 7, 0, 0);  add(0, 1, 20, 0, 0);
        add(0, 0, 10, 0, 0); add(0, 1, 7, 1, 1);  add(0, 0, 10, 1, 1);  add(0, 1, 7, 2, 1);
        add(0, 0, 10, 2, 1); add(0, 1, 7, 3, 1);
        add(1, 1, 1, 0, 0);  add(0, 1, 6, 0, 0);  add(0, 1, 1, 1, 1);
        @(negedge clk);
        foreach (tv[i]) begin
            rst = tv[i].r;
            sw = tv[i].s;
            repeat (tv[i].n) @(negedge clk);
            chk = 1;
            tests++;
            if (mode !== 2'(tv[i].m) || ld !== tv[i].l) begin
                fails++;
                $display("FAIL vec%0d mode=%0d exp=%0d ld=%0d exp=%0d", i, mode, tv[i].m, ld, tv[i].l);
            end
        end
        for (int k = 0; k < 300; k++) begin
            rst = $urandom_range(0, 39) == 0;
            sw = $urandom_range(0, 1) == 1;
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(5, 30) : $urandom_range(1, 6)) @(negedge clk);
        end
        rst = 0;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/flash_ctrl.md
# flash_ctrl

Controller for the board's switch/LED flash path. It turns the raw push-switch `sw` into single debounced press events and uses each press to step through four LED modes: off, steady on, slow blink and fast blink. It drives the LED output `ld` from a shared prescaled tick. The block sits between the board pins and the LED and replaces ad-hoc toggling with a deterministic mode sequencer.

## Interface
- `DEB_CYCLES`, default 625000: cycles `sw` must stay stable before the debounced level changes; ≥1.
- `TICK_CYCLES`, default 62500: clock cycles per blink tick; ≥1.
- `SLOW_TICKS`, default 40: ticks per half-period in SLOW mode; ≥1.
- `FAST_TICKS`, default 8: ticks per half-period in FAST mode; ≥1.
- `clk  input  1  system clock; all logic on its rising edge`
- `rst  input  1  synchronous, active-high reset`
- `sw  input  1  raw switch, asynchronous to clk, bouncy`
- `ld  output  1  LED drive, registered`
- `mode  output  2  current mode, registered: OFF=0, ON=1, SLOW=2, FAST=3`

## Operation
- Reset values, applied on any edge with `rst`=1: `ld`=0, `mode`=OFF. The synchronizer flops, debounced level, debounce counter, prescaler and tick counter are all 0.
- Synchronizer: two flops, `s1`←`sw`, then `s2`←`s1`.
- Debounce:
  - If `s2`≠`stable`, the counter increments.
  - When the counter equals DEB_CYCLES−1 and the mismatch is still present, `stable`←`s2` and the counter clears.
  - If `s2`==`stable`, the counter clears.
- Press: a one-cycle pulse, `stable & ~stable_q`. A falling debounced edge has no effect.
- Mode FSM: OFF→ON→SLOW→FAST→OFF, advancing one step per press. The transition is registered on the edge after the press pulse.
- On every mode change, the prescaler and tick counter clear, and `ld` loads the entry value: OFF=0, ON=1, SLOW=1, FAST=1.
- Prescaler: counts 0..TICK_CYCLES−1 and asserts `tick` at TICK_CYCLES−1. It runs only in SLOW and FAST.
- Blink: on each `tick`, the tick counter increments. When it reaches N−1, `ld` toggles and the counter clears. N is SLOW_TICKS or FAST_TICKS.
- OFF and ON hold `ld` constant.
- Counter widths are `$clog2(param)`, minimum 1. There is no overflow: every counter wraps at its terminal count.

## Timing
- If `sw` changes before edge 1, `stable` updates on edge DEB_CYCLES+2. `mode` and `ld` update on edge DEB_CYCLES+3. This latency is exact.
- A pulse or bounce on `s2` lasting fewer than DEB_CYCLES cycles does not change `stable`.
- Blink half-period is exactly N×TICK_CYCLES cycles. The first toggle occurs that many cycles after mode entry.
- A press and a `tick` in the same cycle: the mode change wins, the counters clear and the tick is discarded.
- Reset mid-operation: outputs take their reset values on the next edge and hold them while `rst`=1.
- A switch held high through reset is seen as a new press. `mode` becomes ON exactly DEB_CYCLES+3 edges after the first edge with `rst`=0.
- The FSM has no illegal states: all four 2-bit encodings are valid.

## Structure
- `flash_pkg` holds:
  - the mode enum/localparams `MODE_OFF`, `MODE_ON`, `MODE_SLOW`, `MODE_FAST`;
  - the width helper.
- Sub-module `flash_debounce` contains the synchronizer, debounce counter and press pulse. Its ports are `clk`, `rst`, `sw`, `stable`, `press`, and it has parameter DEB_CYCLES.
- `flash_ctrl` contains the mode FSM, prescaler, tick counter and `ld` register.

## Test plan
All scenarios use sim parameters DEB_CYCLES=4, TICK_CYCLES=5, SLOW_TICKS=4, FAST_TICKS=1.
1. Hold `rst`=1 for 3 cycles with `sw`=0 → `ld`=0 and `mode`=0 throughout. They stay there for 50 cycles after release.
2. `sw` 0→1 before edge 1, held for 20 cycles, then released → `mode`=1 and `ld`=1 exactly at edge 7. Release causes no change.
3. `sw` high for 3 cycles, then low → `mode`=0 and `ld`=0 for 50 cycles.
4. `sw` toggles every 2 cycles for 10 cycles, then settles high → exactly one press, `mode`=1.
5. Four clean presses → `mode` steps 1, 2, 3, 0. In SLOW, `ld` is 1 for 20 cycles, then 0 for 20 cycles, repeating. In FAST, `ld` toggles every 5 cycles. In OFF, `ld`=0.
6. In FAST, assert `rst` for 1 cycle while `sw` is held high → `ld`=0 and `mode`=0 on that edge. Then `mode`=1 and `ld`=1 exactly 7 edges after `rst` falls.
